// File: rtl/axixl_lite_regfile_responder.sv
// rtl/axixl_lite_regfile_responder.sv - AXI4-Lite register-file responder with independent write/read channels
module axixl_lite_regfile_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam int SW = DW / 8;
  localparam int DEPTH = 1 << IW;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Storage spans the whole index space; entries >= NUM_REGS are never written and stay constant.
  logic [DW-1:0] regs [DEPTH];

  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs, w_hs, commit, wr_mapped, aw_held_n, w_held_n, bvalid_n;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          ar_hs, rd_mapped, rvalid_n;

  // Address byte-lane bits and protection fields carry no meaning for this target.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_hs     = S_AXI_AWVALID & awready_q;
    w_hs      = S_AXI_WVALID & wready_q;
    wr_idx    = aw_hs ? S_AXI_AWADDR[AW-1:2] : aw_idx;
    wr_data   = w_hs ? S_AXI_WDATA : w_data;
    wr_strb   = w_hs ? S_AXI_WSTRB : w_strb;
    commit    = (aw_held | aw_hs) & (w_held | w_hs);
    wr_mapped = 32'(wr_idx) < NUM_REGS_U;
    aw_held_n = ~commit & (aw_held | aw_hs);
    w_held_n  = ~commit & (w_held | w_hs);
    bvalid_n  = commit | (bvalid_q & ~S_AXI_BREADY);
    ar_hs     = S_AXI_ARVALID & arready_q;
    rd_idx    = S_AXI_ARADDR[AW-1:2];
    rd_mapped = 32'(rd_idx) < NUM_REGS_U;
    rvalid_n  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[AW-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        if (wr_mapped)
          for (int k = 0; k < SW; k++)
            if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
      bvalid_q  <= bvalid_n;
      awready_q <= ~aw_held_n & ~bvalid_n;
      wready_q  <= ~w_held_n & ~bvalid_n;
      // Same-edge commit and read see the pre-commit register contents.
      if (ar_hs) begin
        rdata_q <= rd_mapped ? regs[rd_idx] : '0;
        rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
      rvalid_q  <= rvalid_n;
      arready_q <= ~rvalid_n;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule
